// File: rtl/switch_debounce.sv
// Switch/button input conditioning for the LED blinker: two-flop sync,
// counter-based debounce per channel, edge pulses and a button-driven
// enable toggle. All channels share one lane module.

module debounce_chan #(
    parameter int DEBOUNCE_CYCLES = 250_000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic st,
    output logic rise,
    output logic fall
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser; only s2 is trusted downstream.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Count consecutive disagreeing cycles; any agreement restarts the count.
    // Pulses are registered alongside the st flip so they line up with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt  <= '0;
            st   <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (s2 == st) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end else begin
                st   <= s2;
                cnt  <= '0;
                rise <= s2;
                fall <= ~s2;
            end
        end
    end
endmodule

module switch_debounce #(
    parameter int   NUM_SW          = 2,
    parameter int   DEBOUNCE_CYCLES = 250_000,
    parameter logic ENABLE_INIT     = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_SW-1:0] sw_raw,
    input  logic              btn_raw,
    output logic [NUM_SW-1:0] sw_clean,
    output logic [NUM_SW-1:0] sw_rise,
    output logic [NUM_SW-1:0] sw_fall,
    output logic              btn_press,
    output logic              enable
);
    // Lane NUM_SW is the push button; lanes below it are the slide switches.
    logic [NUM_SW:0] chan_raw;
    logic [NUM_SW:0] chan_st;
    logic [NUM_SW:0] chan_rise;
    logic [NUM_SW:0] chan_fall;

    assign chan_raw = {btn_raw, sw_raw};

    generate
        for (genvar i = 0; i <= NUM_SW; i++) begin : g_chan
            debounce_chan #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_chan (
                .clock (clock),
                .reset (reset),
                .raw   (chan_raw[i]),
                .st    (chan_st[i]),
                .rise  (chan_rise[i]),
                .fall  (chan_fall[i])
            );
        end
    endgenerate

    assign sw_clean  = chan_st[NUM_SW-1:0];
    assign sw_rise   = chan_rise[NUM_SW-1:0];
    assign sw_fall   = chan_fall[NUM_SW-1:0];
    assign btn_press = chan_rise[NUM_SW];

    // Button level and release edge have no consumer.
    logic unused_btn;
    assign unused_btn = chan_st[NUM_SW] ^ chan_fall[NUM_SW];

    // One toggle per clean press, landing the cycle after the press pulse.
    always_ff @(posedge clock) begin
        if (reset)          enable <= ENABLE_INIT;
        else if (btn_press) enable <= ~enable;
    end
endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with DEBOUNCE_CYCLES=4, NUM_SW=2.
// Inputs change 1 time unit after a rising edge; outputs are checked there.

module tb_switch_debounce;
    logic       clock;
    logic       reset;
    logic [1:0] sw_raw;
    logic       btn_raw;
    logic [1:0] sw_clean;
    logic [1:0] sw_rise;
    logic [1:0] sw_fall;
    logic       btn_press;
    logic       enable;

    int total = 0;
    int bad   = 0;

    switch_debounce #(
        .NUM_SW(2),
        .DEBOUNCE_CYCLES(4),
        .ENABLE_INIT(1'b1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .sw_raw    (sw_raw),
        .btn_raw   (btn_raw),
        .sw_clean  (sw_clean),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .btn_press (btn_press),
        .enable    (enable)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // exp = {clean[1:0], rise[1:0], fall[1:0], press, enable}
    typedef struct {
        logic       rst;
        logic [1:0] sw;
        logic       btn;
        logic [7:0] exp;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic [1:0] sw, input logic btn,
                       input logic [1:0] cl, input logic [1:0] ri,
                       input logic [1:0] fa, input logic pr, input logic en);
        vec_t v;
        v.rst = rst;
        v.sw  = sw;
        v.btn = btn;
        v.exp = {cl, ri, fa, pr, en};
        vq.push_back(v);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] outs();
        return {sw_clean, sw_rise, sw_fall, btn_press, enable};
    endfunction

    initial begin
        reset   = 1'b1;
        sw_raw  = 2'b00;
        btn_raw = 1'b0;

        // Reset, then quiet hold.
        for (int i = 0; i < 3; i++)  add(1, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 1);
        for (int i = 0; i < 20; i++) add(0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 1);
        // sw0 rises: first sampled at row 0, clean at row 5.
        for (int i = 0; i < 5; i++)  add(0, 2'b01, 0, 2'b00, 2'b00, 2'b00, 0, 1);
        add(0, 2'b01, 0, 2'b01, 2'b01, 2'b00, 0, 1);
        add(0, 2'b01, 0, 2'b01, 2'b00, 2'b00, 0, 1);
        // sw1 bounce of 3 cycles is rejected.
        for (int i = 0; i < 3; i++)  add(0, 2'b11, 0, 2'b01, 2'b00, 2'b00, 0, 1);
        for (int i = 0; i < 4; i++)  add(0, 2'b01, 0, 2'b01, 2'b00, 2'b00, 0, 1);
        // sw1 held long enough.
        for (int i = 0; i < 5; i++)  add(0, 2'b11, 0, 2'b01, 2'b00, 2'b00, 0, 1);
        add(0, 2'b11, 0, 2'b11, 2'b10, 2'b00, 0, 1);
        add(0, 2'b11, 0, 2'b11, 2'b00, 2'b00, 0, 1);

        foreach (vq[i]) begin
            reset   = vq[i].rst;
            sw_raw  = vq[i].sw;
            btn_raw = vq[i].btn;
            tick();
            check($sformatf("vec%0d", i), outs(), vq[i].exp);
        end

        // Button: two press/hold/release cycles, one toggle each.
        for (int p = 0; p < 2; p++) begin
            logic en0;
            en0 = (p == 0) ? 1'b1 : 1'b0;
            btn_raw = 1'b1;
            for (int k = 0; k < 30; k++) begin
                tick();
                check($sformatf("btn_hold%0d_press_k%0d", p, k), {7'd0, btn_press}, {7'd0, k == 5});
                check($sformatf("btn_hold%0d_en_k%0d", p, k), {7'd0, enable}, {7'd0, (k >= 6) ? ~en0 : en0});
            end
            btn_raw = 1'b0;
            for (int k = 0; k < 30; k++) begin
                tick();
                check($sformatf("btn_rel%0d_press_k%0d", p, k), {7'd0, btn_press}, 8'd0);
                check($sformatf("btn_rel%0d_en_k%0d", p, k), {7'd0, enable}, {7'd0, ~en0});
            end
        end

        // Both switches fall together, then rise together, then fall again.
        for (int s = 0; s < 3; s++) begin
            logic [1:0] tgt;
            logic [1:0] prv;
            tgt = (s == 1) ? 2'b11 : 2'b00;
            prv = ~tgt;
            sw_raw = tgt;
            for (int k = 0; k < 8; k++) begin
                logic [1:0] cl;
                logic [1:0] ri;
                logic [1:0] fa;
                tick();
                cl = (k >= 5) ? tgt : prv;
                ri = (k == 5 && tgt == 2'b11) ? 2'b11 : 2'b00;
                fa = (k == 5 && tgt == 2'b00) ? 2'b11 : 2'b00;
                check($sformatf("pair%0d_k%0d", s, k), outs(), {cl, ri, fa, 1'b0, 1'b1});
            end
        end

        // Third press brings enable to 0 ahead of the reset test.
        btn_raw = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        btn_raw = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check("pre_reset_en", {7'd0, enable}, 8'd0);

        // Reset mid-debounce (cnt reached 2), raw sw0 still high afterwards.
        sw_raw = 2'b01;
        for (int k = 0; k < 4; k++) tick();
        check("mid_debounce", outs(), 8'b00_00_00_0_0);
        reset = 1'b1;
        tick();
        check("reset_mid", outs(), 8'b00_00_00_0_1);
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("post_reset_k%0d", k), outs(),
                  (k == 6) ? 8'b01_01_00_0_1 : 8'b00_00_00_0_1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/switch_debounce.md
Name: switch_debounce

Overview:
- Input-conditioning stage that sits directly upstream of the LED blink block.
- Synchronises and debounces the raw board slide switches and a push button, then drives the clean `sw1`, `sw2` and `enable` inputs of the blinker.
- The push button toggles a registered `enable` level.
- Per-switch edge pulses are also produced for other consumers.

Parameters:
- NUM_SW, 2: number of slide-switch channels. `sw_clean[0]` feeds blinker `sw1`; `sw_clean[1]` feeds blinker `sw2`.
- DEBOUNCE_CYCLES, 250_000: consecutive stable cycles required before a channel's clean output changes. This is 5 ms at a 50 MHz / 20 ns clock. Legal range is ≥1.
- ENABLE_INIT, 1'b1: value loaded into `enable` on reset.
- CNT_W is a localparam, not a parameter: `$clog2(DEBOUNCE_CYCLES)`, minimum 1.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- sw_raw  input  NUM_SW  asynchronous raw slide-switch levels.
- btn_raw  input  1  asynchronous raw push-button level; 1 = pressed.
- sw_clean  output  NUM_SW  debounced switch levels.
- sw_rise  output  NUM_SW  one-cycle pulse per channel on a clean 0→1 transition.
- sw_fall  output  NUM_SW  one-cycle pulse per channel on a clean 1→0 transition.
- btn_press  output  1  one-cycle pulse on a clean button 0→1 transition.
- enable  output  1  toggle register driven by button presses; feeds blinker `enable`.

Behaviour:
- Interface: one clock, `clock`; reset `reset` is synchronous, active-high. All state updates on the rising edge of `clock` only.
- Reset (any cycle, including mid-debounce) takes effect at the next rising edge:
  - synchroniser flops, counters, `sw_clean`, `sw_rise`, `sw_fall` and `btn_press` go to 0;
  - `enable` goes to ENABLE_INIT;
  - reset overrides every other event in the same cycle.
- Channels: NUM_SW switch channels plus one button channel. All are identical and independent.
- Synchroniser:
  - Each raw input passes through two flops (`s1`, then `s2`).
  - Only `s2` is used downstream.
- Debounce, per channel (counter `cnt`, stable bit `st`):
  - If `s2 == st`: `cnt <= 0`.
  - If `s2 != st` and `cnt != DEBOUNCE_CYCLES-1`: `cnt <= cnt+1`.
  - If `s2 != st` and `cnt == DEBOUNCE_CYCLES-1`: `st <= s2` and `cnt <= 0`.
- Latency: a raw change first sampled at edge E0 and held changes `st` at edge E0+DEBOUNCE_CYCLES+1.
- Glitch rejection: any return of `s2` to `st` before the terminal count clears `cnt`. The clean output does not change, and no pulses are generated.
- `sw_clean` = switch `st` bits, driven directly from the register.
- Pulses:
  - `sw_rise[i]` / `sw_fall[i]` / `btn_press` are registered and asserted at the same edge that flips `st`.
  - Each is high for exactly one cycle and never asserted in consecutive cycles.
  - Rise and fall of the same channel are never both high.
- Enable:
  - At the edge following a cycle where `btn_press` = 1, `enable <= ~enable`. This is one cycle after the press pulse.
  - Holding the button produces exactly one toggle.
  - Releasing the button produces no toggle.
- Post-reset: if a raw input is already high during reset, the channel debounces to 1 after release and emits a rise pulse. A held button therefore toggles `enable` once after reset.
- Simultaneous events: channels never interact. Toggling two switches in the same cycle yields both pulses in the same cycle.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.

Test Plan (DEBOUNCE_CYCLES=4, NUM_SW=2, ENABLE_INIT=1):
1. Reset for 3 cycles with all raw inputs 0 → `sw_clean`=2'b00, all pulses 0, `enable`=1. Hold 20 cycles → outputs unchanged.
2. `sw_raw`=2'b01 first sampled at edge E0 → `sw_clean`=2'b01 and `sw_rise`=2'b01 at edge E0+5. `sw_rise` is back to 0 at E0+6.
3. `sw_raw[1]` pulsed high for 3 cycles, then 0 (bounce) → `sw_clean[1]` stays 0 and no `sw_rise[1]`. A subsequent 6-cycle high → `sw_clean[1]`=1 at E0+5.
4. `btn_raw` held high for 30 cycles, then low for 30 → exactly one `btn_press`, and `enable` 1→0 one cycle after it. The release produces no toggle. A second press → `enable` returns to 1.
5. Raw inputs 2'b11 sampled at the same edge → both rise pulses in the same cycle. Dropping both to 0 → both `sw_fall` bits pulse together after 5 edges.
6. Assert `reset` while `cnt`=2 mid-debounce with `enable`=0 → next edge: `cnt`=0, `enable`=1, `sw_clean`=0. With the raw input still high, `sw_clean` rises 5 edges after reset deasserts.
